// File: rtl/maxnet_pkg.sv
// Shared definitions for the Maxnet initiator: operand width, default done
// timeout and the driver's state encoding.
package maxnet_pkg;

   localparam int W           = 5;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FIRE    = 2'd1,
      WAIT    = 2'd2,
      OUTPUT  = 2'd3
   } state_t;

endpackage

// File: rtl/maxnet_driver_if.sv
// Sample-in / result-out stream bundle. The master side feeds samples and
// drains results; the slave side is the driver.
interface maxnet_driver_if;
   import maxnet_pkg::*;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_err;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_err
   );

endinterface

// File: rtl/maxnet_operand_reg.sv
// Four-entry operand store feeding mn_X1..mn_X4; written one sample at a time.
module maxnet_operand_reg
   import maxnet_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [1:0]   widx,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] x1,
   output logic [W-1:0] x2,
   output logic [W-1:0] x3,
   output logic [W-1:0] x4
);

   logic [W-1:0] mem [4];

   // NOTE: this tiny file is reset because the operands must read 0 right
   // after reset; larger RAM-style arrays are normally left unreset.
   // NOTE: sequential state uses <= so every register updates from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign x1 = mem[0];
   assign x2 = mem[1];
   assign x3 = mem[2];
   assign x4 = mem[3];

endmodule

// File: rtl/maxnet_driver.sv
// Packs four serial samples into the Maxnet operands, starts the core, waits
// (bounded) for done and hands the winner downstream on a valid/ready port.
module maxnet_driver
   import maxnet_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   maxnet_driver_if.slave    stream,
   output logic              mn_start,
   output logic [W-1:0]      mn_X1,
   output logic [W-1:0]      mn_X2,
   output logic [W-1:0]      mn_X3,
   output logic [W-1:0]      mn_X4,
   input  logic              mn_done,
   input  logic [W-1:0]      mn_result,
   output logic              busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state, state_nxt;
   logic [1:0]    count, count_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [W-1:0]  data_q, data_nxt;
   logic          err_q, err_nxt;
   logic          we;

   maxnet_operand_reg u_operands (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .widx  (count),
      .wdata (stream.in_data),
      .x1    (mn_X1),
      .x2    (mn_X2),
      .x3    (mn_X3),
      .x4    (mn_X4)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= COLLECT;
         count  <= '0;
         timer  <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         count  <= count_nxt;
         timer  <= timer_nxt;
         data_q <= data_nxt;
         err_q  <= err_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_nxt        = state;
      count_nxt        = count;
      timer_nxt        = timer;
      data_nxt         = data_q;
      err_nxt          = err_q;
      we               = 1'b0;
      mn_start         = 1'b0;
      stream.in_ready  = 1'b0;
      stream.out_valid = 1'b0;

      case (state)
         COLLECT: begin
            stream.in_ready = 1'b1;
            if (stream.in_valid) begin
               we        = 1'b1;
               count_nxt = count + 2'd1;  // wraps to 0 after the fourth sample
               if (count == 2'd3) state_nxt = FIRE;
            end
         end
         FIRE: begin
            mn_start  = 1'b1;
            timer_nxt = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            // Done takes priority over a timeout landing in the same cycle.
            if (mn_done) begin
               data_nxt  = mn_result;
               err_nxt   = 1'b0;
               state_nxt = OUTPUT;
            end else if (timer == TW'(TIMEOUT - 1)) begin
               data_nxt  = '0;
               err_nxt   = 1'b1;
               state_nxt = OUTPUT;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         OUTPUT: begin
            stream.out_valid = 1'b1;
            if (stream.out_ready) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

   assign stream.out_data = data_q;
   assign stream.out_err  = err_q;
   assign busy            = !(state == COLLECT && count == 2'd0);

endmodule

// File: tb/tb_maxnet_driver.sv
// Directed bench for maxnet_driver: the bench plays both the sample source and
// a scripted Maxnet core, with a short done timeout of 8 cycles.
module tb_maxnet_driver;
   import maxnet_pkg::*;

   localparam int TB_TIMEOUT = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         mn_start;
   logic [W-1:0] mn_X1, mn_X2, mn_X3, mn_X4;
   logic         mn_done;
   logic [W-1:0] mn_result;
   logic         busy;
   int           errs   = 0;
   int           checks = 0;
   int           xfers  = 0;

   maxnet_driver_if bus ();

   maxnet_driver #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .stream    (bus),
      .mn_start  (mn_start),
      .mn_X1     (mn_X1),
      .mn_X2     (mn_X2),
      .mn_X3     (mn_X3),
      .mn_X4     (mn_X4),
      .mn_done   (mn_done),
      .mn_result (mn_result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.out_valid && bus.out_ready) xfers++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feeds four back-to-back samples; returns in the FIRE cycle.
   task automatic send4(input logic [W-1:0] a, b, c, d);
      logic [W-1:0] s [4];
      s = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = s[i];
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic accept();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      mn_done = 1'b0; mn_result = '0;
      repeat (2) tick();
      checks++; if ({mn_X1, mn_X2, mn_X3, mn_X4} !== '0) begin errs++; $display("FAIL reset_operands: got %h expected 0", {mn_X1, mn_X2, mn_X3, mn_X4}); end
      checks++; if (mn_start !== 1'b0) begin errs++; $display("FAIL reset_start: got %b expected 0", mn_start); end
      checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      checks++; if (bus.out_data !== '0 || bus.out_err !== 1'b0) begin errs++; $display("FAIL reset_out_data: got %0d/%b expected 0/0", bus.out_data, bus.out_err); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      tick();
      checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL idle_ready: got in_ready=%b busy=%b expected 1/0", bus.in_ready, busy); end
   endtask

   task automatic test_basic();
      send4(5'd3, 5'd17, 5'd9, 5'd5);
      checks++; if (mn_start !== 1'b1) begin errs++; $display("FAIL basic_start: got %b expected 1", mn_start); end
      checks++; if ({mn_X1, mn_X2, mn_X3, mn_X4} !== {5'd3, 5'd17, 5'd9, 5'd5}) begin errs++; $display("FAIL basic_operands: got %h expected %h", {mn_X1, mn_X2, mn_X3, mn_X4}, {5'd3, 5'd17, 5'd9, 5'd5}); end
      checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL basic_fire_flags: got in_ready=%b busy=%b expected 0/1", bus.in_ready, busy); end
      tick();
      checks++; if (mn_start !== 1'b0) begin errs++; $display("FAIL basic_start_width: got %b expected 0", mn_start); end
      repeat (3) tick();
      mn_done = 1'b1; mn_result = 5'd17;
      checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL basic_early_valid: got %b expected 0", bus.out_valid); end
      tick();
      mn_done = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 5'd17 || bus.out_err !== 1'b0) begin errs++; $display("FAIL basic_result: got v=%b d=%0d e=%b expected 1/17/0", bus.out_valid, bus.out_data, bus.out_err); end
      accept();
      checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL basic_after_accept: got v=%b busy=%b expected 0/0", bus.out_valid, busy); end
   endtask

   task automatic test_gapped();
      logic [W-1:0] s [4];
      s = '{5'd31, 5'd0, 5'd0, 5'd1};
      for (int i = 0; i <= 6; i++) begin
         bus.in_valid = (i % 2 == 0);
         bus.in_data  = (i % 2 == 0) ? s[i / 2] : 5'h15;
         tick();
         if (i < 6) begin
            checks++; if (mn_start !== 1'b0) begin errs++; $display("FAIL gapped_early_start: step %0d got %b expected 0", i, mn_start); end
         end
      end
      bus.in_valid = 1'b0;
      checks++; if (mn_start !== 1'b1) begin errs++; $display("FAIL gapped_start: got %b expected 1", mn_start); end
      checks++; if ({mn_X1, mn_X2, mn_X3, mn_X4} !== {5'd31, 5'd0, 5'd0, 5'd1}) begin errs++; $display("FAIL gapped_operands: got %h expected %h", {mn_X1, mn_X2, mn_X3, mn_X4}, {5'd31, 5'd0, 5'd0, 5'd1}); end
      tick();
      mn_done = 1'b1; mn_result = 5'd31;
      tick();
      mn_done = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 5'd31 || bus.out_err !== 1'b0) begin errs++; $display("FAIL gapped_result: got v=%b d=%0d e=%b expected 1/31/0", bus.out_valid, bus.out_data, bus.out_err); end
      accept();
   endtask

   task automatic test_backpressure();
      send4(5'd1, 5'd2, 5'd3, 5'd4);
      tick();
      mn_done = 1'b1; mn_result = 5'd21;
      tick();
      mn_done = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 5'd9;
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 5'd21 || bus.in_ready !== 1'b0 ||
             {mn_X1, mn_X2, mn_X3, mn_X4} !== {5'd1, 5'd2, 5'd3, 5'd4}) begin
            errs++;
            $display("FAIL stall_hold: cycle %0d got v=%b d=%0d rdy=%b x=%h expected 1/21/0/%h", k, bus.out_valid, bus.out_data, bus.in_ready, {mn_X1, mn_X2, mn_X3, mn_X4}, {5'd1, 5'd2, 5'd3, 5'd4});
         end
         tick();
      end
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL stall_eleventh: got %b expected 1", bus.out_valid); end
      accept();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL stall_release: got v=%b rdy=%b busy=%b expected 0/1/0", bus.out_valid, bus.in_ready, busy); end
   endtask

   task automatic test_timeout();
      send4(5'd10, 5'd11, 5'd12, 5'd13);
      tick();
      for (int k = 0; k < TB_TIMEOUT; k++) begin
         checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL timeout_early: wait cycle %0d got %b expected 0", k, bus.out_valid); end
         tick();
      end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 5'd0 || bus.out_err !== 1'b1) begin errs++; $display("FAIL timeout_result: got v=%b d=%0d e=%b expected 1/0/1", bus.out_valid, bus.out_data, bus.out_err); end
      accept();
      // Done arriving on the last allowed wait cycle beats the timeout.
      send4(5'd6, 5'd7, 5'd8, 5'd9);
      tick();
      repeat (TB_TIMEOUT - 1) tick();
      mn_done = 1'b1; mn_result = 5'd6;
      checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL limit_early: got %b expected 0", bus.out_valid); end
      tick();
      mn_done = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 5'd6 || bus.out_err !== 1'b0) begin errs++; $display("FAIL limit_result: got v=%b d=%0d e=%b expected 1/6/0", bus.out_valid, bus.out_data, bus.out_err); end
      accept();
   endtask

   task automatic test_reset_mid_wait();
      send4(5'd1, 5'd2, 5'd3, 5'd4);
      repeat (2) tick();
      #2 rst = 1'b1;
      #1;
      checks++; if ({mn_X1, mn_X2, mn_X3, mn_X4} !== '0 || mn_start !== 1'b0) begin errs++; $display("FAIL areset_operands: got x=%h start=%b expected 0/0", {mn_X1, mn_X2, mn_X3, mn_X4}, mn_start); end
      checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL areset_outputs: got v=%b d=%0d e=%b busy=%b expected all 0", bus.out_valid, bus.out_data, bus.out_err, busy); end
      #3 rst = 1'b0;
      tick();
      mn_done = 1'b1; mn_result = 5'd12;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL late_done: cycle %0d got v=%b busy=%b expected 0/0", k, bus.out_valid, busy); end
      end
      mn_done = 1'b0;
      send4(5'd8, 5'd9, 5'd10, 5'd11);
      tick();
      mn_done = 1'b1; mn_result = 5'd10;
      tick();
      mn_done = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 5'd10 || {mn_X1, mn_X2, mn_X3, mn_X4} !== {5'd8, 5'd9, 5'd10, 5'd11}) begin errs++; $display("FAIL post_reset_group: got v=%b d=%0d x=%h expected 1/10/%h", bus.out_valid, bus.out_data, {mn_X1, mn_X2, mn_X3, mn_X4}, {5'd8, 5'd9, 5'd10, 5'd11}); end
      accept();
   endtask

   task automatic test_held_done();
      logic [W-1:0] res [2];
      int           x0;
      res = '{5'd7, 5'd20};
      mn_done = 1'b1;
      for (int g = 0; g < 2; g++) begin
         mn_result = res[g];
         x0 = xfers;
         send4(res[g], 5'd1, 5'd2, 5'd3);
         checks++; if (mn_start !== 1'b1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL held_fire: group %0d got start=%b v=%b expected 1/0", g, mn_start, bus.out_valid); end
         tick();
         checks++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL held_fire_capture: group %0d got v=%b expected 0", g, bus.out_valid); end
         tick();
         checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== res[g] || bus.out_err !== 1'b0) begin errs++; $display("FAIL held_result: group %0d got v=%b d=%0d e=%b expected 1/%0d/0", g, bus.out_valid, bus.out_data, bus.out_err, res[g]); end
         accept();
         repeat (3) tick();
         checks++; if (xfers - x0 !== 1 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL held_single_xfer: group %0d got %0d transfers v=%b expected 1/0", g, xfers - x0, bus.out_valid); end
      end
      mn_done = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gapped();
      test_backpressure();
      test_timeout();
      test_reset_mid_wait();
      test_held_done();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
